// File: rtl/qracc_pkg.sv
// Shared types and defaults for the QRAcc output stage: requant config, stream FSM states,
// and a small pointer-wrap helper.
package qracc_pkg;

  localparam int OUT_BITS_DEF     = 8;
  localparam int BUS_ELEMENTS_DEF = 8;
  localparam int SHIFT_W          = 4;

  typedef struct packed {
    logic [SHIFT_W-1:0] shift;
    logic               relu;
    logic               unsigned_sat;
  } qracc_out_cfg_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } out_state_e;

  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 >= depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/qracc_requant.sv
// One-lane combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// then saturation to a signed or unsigned OUT_BITS range.
module qracc_requant
  import qracc_pkg::*;
#(
  parameter int ACC_BITS = 16,
  parameter int OUT_BITS = OUT_BITS_DEF
) (
  input  logic [ACC_BITS-1:0] acc_i,
  input  qracc_out_cfg_t      cfg_i,
  output logic [OUT_BITS-1:0] q_o
);

  // One guard bit so the rounding add can never wrap.
  localparam int W = ACC_BITS + 1;
  localparam logic signed [W-1:0] SMAX = W'((1 << (OUT_BITS - 1)) - 1);
  localparam logic signed [W-1:0] SMIN = ~SMAX;
  localparam logic signed [W-1:0] UMAX = W'((1 << OUT_BITS) - 1);

  logic signed [W-1:0] wide;
  logic signed [W-1:0] half;
  logic signed [W-1:0] shifted;

  // NOTE: combinational logic uses blocking assignments, and every output gets a default
  // at the top of the block so no path can leave it unassigned and infer a latch.
  always_comb begin
    wide = $signed({acc_i[ACC_BITS-1], acc_i});
    half = '0;
    if (cfg_i.shift != '0) half = W'(1) << (cfg_i.shift - 1'b1);
    shifted = (wide + half) >>> cfg_i.shift;
    if (cfg_i.relu && shifted < 0) shifted = '0;

    q_o = shifted[OUT_BITS-1:0];
    if (cfg_i.unsigned_sat) begin
      if (shifted < 0)         q_o = '0;
      else if (shifted > UMAX) q_o = UMAX[OUT_BITS-1:0];
    end else begin
      if (shifted > SMAX)      q_o = SMAX[OUT_BITS-1:0];
      else if (shifted < SMIN) q_o = SMIN[OUT_BITS-1:0];
    end
  end

endmodule

// File: rtl/qracc_output_stage.sv
// Requantizes accumulator result vectors, buffers them in a small vector FIFO and streams
// them as bus-wide beats over ready/valid; vectors arriving while full are dropped and flagged.
module qracc_output_stage
  import qracc_pkg::*;
#(
  parameter int OUTPUT_ELEMENTS = 32,
  parameter int ACC_BITS        = 16,
  parameter int OUT_BITS        = OUT_BITS_DEF,
  parameter int BUS_ELEMENTS    = BUS_ELEMENTS_DEF,
  parameter int FIFO_DEPTH      = 2,
  localparam int BEATS          = OUTPUT_ELEMENTS / BUS_ELEMENTS,
  localparam int BEAT_W         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic [SHIFT_W-1:0]                  cfg_shift_i,
  input  logic                                cfg_relu_i,
  input  logic                                cfg_unsigned_i,
  input  logic                                valid_i,
  input  logic [OUTPUT_ELEMENTS*ACC_BITS-1:0] data_i,
  output logic                                wr_valid_o,
  input  logic                                wr_ready_i,
  output logic [BUS_ELEMENTS*OUT_BITS-1:0]    wr_data_o,
  output logic [BEAT_W-1:0]                   wr_beat_o,
  output logic                                wr_last_o,
  input  logic                                clr_overflow_i,
  output logic                                overflow_o,
  output logic                                busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [BEATS-1:0][BUS_ELEMENTS*OUT_BITS-1:0] vec_t;

  qracc_out_cfg_t                              cfg;
  logic [OUTPUT_ELEMENTS-1:0][OUT_BITS-1:0]    quant;

  assign cfg = '{shift: cfg_shift_i, relu: cfg_relu_i, unsigned_sat: cfg_unsigned_i};

  for (genvar e = 0; e < OUTPUT_ELEMENTS; e++) begin : g_lane
    qracc_requant #(
      .ACC_BITS (ACC_BITS),
      .OUT_BITS (OUT_BITS)
    ) u_requant (
      .acc_i (data_i[e*ACC_BITS +: ACC_BITS]),
      .cfg_i (cfg),
      .q_o   (quant[e])
    );
  end

  vec_t              mem_q [FIFO_DEPTH];
  out_state_e        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              is_last, hs, pop, push, drop, full;

  always_comb begin
    is_last    = (beat_q == BEAT_W'(BEATS - 1));
    hs         = (state_q == ST_STREAM) && wr_ready_i;
    pop        = hs && is_last;
    full       = (cnt_q == CNT_W'(FIFO_DEPTH));
    push       = valid_i && (!full || pop);
    drop       = valid_i && !push;

    wr_ptr_d   = push ? PTR_W'(wrap_inc(32'(wr_ptr_q), FIFO_DEPTH)) : wr_ptr_q;
    rd_ptr_d   = pop  ? PTR_W'(wrap_inc(32'(rd_ptr_q), FIFO_DEPTH)) : rd_ptr_q;

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;

    beat_d = beat_q;
    if (pop)     beat_d = '0;
    else if (hs) beat_d = beat_q + 1'b1;

    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (push) state_d = ST_STREAM;
      ST_STREAM: if (pop && cnt_d == '0) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // A drop in the same cycle as a clear must leave the flag set.
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (clr_overflow_i) overflow_d = 1'b0;

    busy_d = (cnt_d != '0);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

  // NOTE: vector storage is deliberately not reset; it is only observable while
  // streaming, and the payload is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= vec_t'(quant);
  end

  assign wr_valid_o = (state_q == ST_STREAM);
  assign wr_data_o  = wr_valid_o ? mem_q[rd_ptr_q][beat_q] : '0;
  assign wr_beat_o  = beat_q;
  assign wr_last_o  = wr_valid_o && is_last;
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_qracc_output_stage.sv
// Scoreboard bench for qracc_output_stage: expected beats are queued when a vector is driven
// and compared as the write bus hands them off; drops and the overflow flag are predicted too.
module tb_qracc_output_stage;

  localparam int NE    = 32;
  localparam int AB    = 16;
  localparam int OB    = 8;
  localparam int BE    = 8;
  localparam int DEPTH = 2;
  localparam int BEATS = NE / BE;
  localparam int BW    = 2;

  typedef logic [NE-1:0][AB-1:0] dvec_t;
  typedef logic [NE-1:0][OB-1:0] qvec_t;
  typedef struct packed {
    logic [BE*OB-1:0] data;
    logic [BW-1:0]    beat;
    logic             last;
  } beat_t;

  logic              clk;
  logic              nrst;
  logic [3:0]        cfg_shift_i;
  logic              cfg_relu_i;
  logic              cfg_unsigned_i;
  logic              valid_i;
  logic [NE*AB-1:0]  data_i;
  logic              wr_valid_o;
  logic              wr_ready_i;
  logic [BE*OB-1:0]  wr_data_o;
  logic [BW-1:0]     wr_beat_o;
  logic              wr_last_o;
  logic              clr_overflow_i;
  logic              overflow_o;
  logic              busy_o;

  qracc_output_stage #(
    .OUTPUT_ELEMENTS (NE),
    .ACC_BITS        (AB),
    .OUT_BITS        (OB),
    .BUS_ELEMENTS    (BE),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .cfg_shift_i    (cfg_shift_i),
    .cfg_relu_i     (cfg_relu_i),
    .cfg_unsigned_i (cfg_unsigned_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .wr_valid_o     (wr_valid_o),
    .wr_ready_i     (wr_ready_i),
    .wr_data_o      (wr_data_o),
    .wr_beat_o      (wr_beat_o),
    .wr_last_o      (wr_last_o),
    .clr_overflow_i (clr_overflow_i),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t sb[$];
  bit    exp_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OB-1:0] ref_q(input logic signed [AB-1:0] x, input int sh,
                                          input bit relu, input bit uns);
    int v;
    v = int'(x);
    if (sh > 0) v = (v + (1 << (sh - 1))) >>> sh;
    if (relu && v < 0) v = 0;
    if (uns) begin
      if (v < 0) v = 0;
      if (v > 255) v = 255;
    end else begin
      if (v < -128) v = -128;
      if (v > 127) v = 127;
    end
    return v[OB-1:0];
  endfunction

  function automatic qvec_t ref_vec(input dvec_t d, input int sh, input bit relu, input bit uns);
    qvec_t q;
    for (int i = 0; i < NE; i++) q[i] = ref_q(d[i], sh, relu, uns);
    return q;
  endfunction

  function automatic dvec_t rand_vec();
    dvec_t d;
    for (int i = 0; i < NE; i++) d[i] = AB'($urandom);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one valid_i pulse; called just after an edge, returns just after the sampling edge.
  task automatic send_vec(input dvec_t d, input qvec_t q, input logic [3:0] sh,
                          input logic relu, input logic uns);
    int    occ;
    bit    acc;
    beat_t e;
    occ = (sb.size() + BEATS - 1) / BEATS;
    acc = (occ < DEPTH) || ((sb.size() % BEATS) == 1 && wr_ready_i);
    data_i         = d;
    cfg_shift_i    = sh;
    cfg_relu_i     = relu;
    cfg_unsigned_i = uns;
    valid_i        = 1'b1;
    if (acc) begin
      for (int b = 0; b < BEATS; b++) begin
        e.data = q[b*BE +: BE];
        e.beat = BW'(b);
        e.last = (b == BEATS - 1);
        sb.push_back(e);
      end
      if (clr_overflow_i) exp_ovf = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
    step();
    valid_i        = 1'b0;
    data_i         = '0;
    cfg_shift_i    = 4'($urandom);
    cfg_relu_i     = 1'($urandom);
    cfg_unsigned_i = 1'($urandom);
  endtask

  task automatic drain();
    wr_ready_i = 1'b1;
    for (int i = 0; i < 300 && (sb.size() != 0 || busy_o); i++) step();
    check("drain_sb_empty", 64'(sb.size()), 64'd0);
    check("drain_busy", 64'(busy_o), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(wr_valid_o), 64'd0);
    check({tag, "_data"}, 64'(wr_data_o), 64'd0);
    check({tag, "_beat"}, 64'(wr_beat_o), 64'd0);
    check({tag, "_last"}, 64'(wr_last_o), 64'd0);
    check({tag, "_ovf"}, 64'(overflow_o), 64'd0);
    check({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Monitor: compare handed-off beats against the scoreboard and check hold-while-stalled.
  bit               stall_prev = 1'b0;
  logic [BE*OB-1:0] prev_data;
  logic [BW-1:0]    prev_beat;
  logic             prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (!nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", 64'(wr_valid_o), 64'd1);
        check("hold_data", 64'(wr_data_o), 64'(prev_data));
        check("hold_beat", 64'(wr_beat_o), 64'(prev_beat));
        check("hold_last", 64'(wr_last_o), 64'(prev_last));
      end
      if (wr_valid_o && wr_ready_i) begin
        check("beat_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat_data", 64'(wr_data_o), 64'(e.data));
          check("beat_index", 64'(wr_beat_o), 64'(e.beat));
          check("beat_last", 64'(wr_last_o), 64'(e.last));
        end
      end
      stall_prev = wr_valid_o && !wr_ready_i;
      prev_data  = wr_data_o;
      prev_beat  = wr_beat_o;
      prev_last  = wr_last_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dvec_t d;
    qvec_t q;

    nrst = 1'b0; valid_i = 1'b0; data_i = '0; wr_ready_i = 1'b0; clr_overflow_i = 1'b0;
    cfg_shift_i = '0; cfg_relu_i = 1'b0; cfg_unsigned_i = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    nrst = 1'b1;
    step();

    // Signed, shift 4: rounding and both saturation limits; check 1-cycle latency.
    wr_ready_i = 1'b1;
    d = rand_vec();
    d[0] = 16'sd23; d[1] = -16'sd24; d[2] = 16'sd32767; d[3] = 16'h8000;
    q = ref_vec(d, 4, 0, 0);
    q[0] = 8'd1; q[1] = 8'hFF; q[2] = 8'd127; q[3] = 8'h80;
    send_vec(d, q, 4'd4, 1'b0, 1'b0);
    check("latency_valid", 64'(wr_valid_o), 64'd1);
    check("latency_beat", 64'(wr_beat_o), 64'd0);
    drain();

    // Shift 0 passes values through.
    d = rand_vec();
    d[0] = 16'sd100;
    q = ref_vec(d, 0, 0, 0);
    q[0] = 8'd100;
    send_vec(d, q, 4'd0, 1'b0, 1'b0);
    drain();

    // ReLU + unsigned, shift 2.
    d = rand_vec();
    d[0] = -16'sd7; d[1] = 16'sd6; d[2] = 16'sd2000;
    q = ref_vec(d, 2, 1, 1);
    q[0] = 8'd0; q[1] = 8'd2; q[2] = 8'd255;
    send_vec(d, q, 4'd2, 1'b1, 1'b1);
    drain();

    // Ramp 0..31, ready high: four beats back to back, busy drops after the last.
    for (int i = 0; i < NE; i++) begin
      d[i] = AB'(i);
      q[i] = OB'(i);
    end
    send_vec(d, q, 4'd0, 1'b0, 1'b0);
    check("ramp_busy_up", 64'(busy_o), 64'd1);
    repeat (3) step();
    check("ramp_last_beat", 64'(wr_beat_o), 64'd3);
    check("ramp_last_flag", 64'(wr_last_o), 64'd1);
    check("ramp_last_data", 64'(wr_data_o), 64'h1f1e1d1c1b1a1918);
    step();
    check("ramp_valid_down", 64'(wr_valid_o), 64'd0);
    check("ramp_busy_down", 64'(busy_o), 64'd0);

    // Stall 10 cycles mid-vector; the monitor checks hold and completeness.
    d = rand_vec();
    send_vec(d, ref_vec(d, 3, 0, 0), 4'd3, 1'b0, 1'b0);
    repeat (2) step();
    wr_ready_i = 1'b0;
    repeat (10) step();
    check("stall_beat", 64'(wr_beat_o), 64'd2);
    drain();

    // Overflow: three pulses into a depth-2 FIFO with ready low.
    wr_ready_i = 1'b0;
    for (int v = 0; v < 3; v++) begin
      d = rand_vec();
      send_vec(d, ref_vec(d, v, 0, 0), 4'(v), 1'b0, 1'b0);
    end
    check("ovf_set", 64'(overflow_o), 64'(exp_ovf));
    check("ovf_set_abs", 64'(overflow_o), 64'd1);
    repeat (3) step();
    check("ovf_sticky", 64'(overflow_o), 64'd1);
    clr_overflow_i = 1'b1;
    step();
    clr_overflow_i = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared", 64'(overflow_o), 64'd0);
    clr_overflow_i = 1'b1;
    d = rand_vec();
    send_vec(d, ref_vec(d, 1, 0, 0), 4'd1, 1'b0, 1'b0);
    clr_overflow_i = 1'b0;
    check("ovf_set_wins", 64'(overflow_o), 64'd1);
    clr_overflow_i = 1'b1;
    step();
    clr_overflow_i = 1'b0;
    exp_ovf = 1'b0;
    check("ovf_cleared2", 64'(overflow_o), 64'd0);

    // Push on the last-beat pop while full is accepted.
    wr_ready_i = 1'b1;
    for (int i = 0; i < 20 && !wr_last_o; i++) step();
    check("full_last_seen", 64'(wr_last_o), 64'd1);
    d = rand_vec();
    send_vec(d, ref_vec(d, 5, 1, 0), 4'd5, 1'b1, 1'b0);
    check("full_pop_push_no_ovf", 64'(overflow_o), 64'd0);
    drain();

    // Reset mid-vector with two entries queued and overflow set.
    wr_ready_i = 1'b0;
    for (int v = 0; v < 3; v++) begin
      d = rand_vec();
      send_vec(d, ref_vec(d, 2, 0, 1), 4'd2, 1'b0, 1'b1);
    end
    check("pre_reset_ovf", 64'(overflow_o), 64'd1);
    wr_ready_i = 1'b1;
    step();
    nrst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    step();
    check_reset_outputs("midreset");
    nrst = 1'b1;
    d = rand_vec();
    send_vec(d, ref_vec(d, 6, 0, 0), 4'd6, 1'b0, 1'b0);
    check("post_reset_valid", 64'(wr_valid_o), 64'd1);
    check("post_reset_beat", 64'(wr_beat_o), 64'd0);
    drain();

    // Random traffic: random cfg, random ready, occasional clears; drops predicted.
    for (int c = 0; c < 150; c++) begin
      check("rand_ovf", 64'(overflow_o), 64'(exp_ovf));
      wr_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(4) == 0) begin
        d = rand_vec();
        cfg_shift_i = 4'($urandom);
        q = ref_vec(d, int'(cfg_shift_i), cfg_relu_i, cfg_unsigned_i);
        send_vec(d, q, cfg_shift_i, cfg_relu_i, cfg_unsigned_i);
      end else if ($urandom_range(15) == 0) begin
        clr_overflow_i = 1'b1;
        step();
        clr_overflow_i = 1'b0;
        exp_ovf = 1'b0;
      end else begin
        step();
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
